// File: rtl/mem_arb_pkg.sv
// Shared constants and parameter checks for the
// multi-channel memory port arbiter.
package mem_arb_pkg;

  localparam int MAX_CH  = 8;
  localparam int MAX_LAT = 4;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_ok(
    input int nch,
    input int dw,
    input int bw,
    input int aw,
    input int lat
  );
    return nch >= 1 && nch <= MAX_CH &&
           dw >= 8 && dw <= bw &&
           aw >= 1 && aw <= bw &&
           lat >= 1 && lat <= MAX_LAT;
  endfunction

endpackage

// File: rtl/mem_port_arb_rr_arbiter.sv
// Round-robin grant: first requester at or above
// ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic         found;
  int           win;
  int           sum;

  // rot[i] is the request of channel (ptr+i) mod N
  always_comb begin
    rot   = N'({req, req} >> ptr);
    found = 1'b0;
    win   = 0;
    sum   = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = int'(ptr) + i;
        win   = (sum >= N) ? sum - N : sum;
      end
    end
    gnt = found ? (N'(1) << win) : '0;
    idx = W'(win);
  end

endmodule

// File: rtl/mem_port_arb.sv
// Multi-channel memory port arbiter with pipelined,
// non-blocking reads tagged by channel ID.
module mem_port_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req_valid,
  input  logic [NUM_CH-1:0]        i_req_we,
  input  logic [NUM_CH*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_req_wdata,
  output logic [NUM_CH-1:0]        o_req_ready,
  output logic [NUM_CH-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_rdata,
  output logic                     o_read_en,
  output logic [BUS_W-1:0]         o_read_addr,
  output logic                     o_write_en,
  output logic [BUS_W-1:0]         o_write_addr,
  output logic [BUS_W-1:0]         o_data,
  input  logic [BUS_W-1:0]         i_data
);

  import mem_arb_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  if (!params_ok(NUM_CH, DATA_W, BUS_W,
                 ADDR_W, RD_LAT)) begin : g_bad
    $error("mem_port_arb: illegal parameters");
  end

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   nxt_ptr;
  logic [CH_W-1:0]   idx;
  logic [NUM_CH-1:0] gnt;
  logic              xfer;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              data_unused;

  logic [RD_LAT:0]   tag_v;
  logic [CH_W-1:0]   tag_id [RD_LAT+1];

  rr_arbiter #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_arb (
    .req (i_req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

  assign o_req_ready = i_rst ? '0 : gnt;
  assign xfer        = |(i_req_valid & o_req_ready);
  assign sel_we      = i_req_we[idx];
  assign sel_addr    =
    i_req_addr[int'(idx)*ADDR_W +: ADDR_W];
  assign sel_wdata   =
    i_req_wdata[int'(idx)*DATA_W +: DATA_W];
  assign nxt_ptr     =
    (int'(idx) == NUM_CH - 1) ? '0 : idx + 1'b1;
  assign data_unused = ^i_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr          <= '0;
      o_read_en    <= 1'b0;
      o_read_addr  <= '0;
      o_write_en   <= 1'b0;
      o_write_addr <= '0;
      o_data       <= '0;
    end else begin
      o_read_en  <= xfer & ~sel_we;
      o_write_en <= xfer & sel_we;
      if (xfer) begin
        ptr <= nxt_ptr;
      end
      if (xfer & ~sel_we) begin
        o_read_addr <= BUS_W'(sel_addr);
      end
      if (xfer & sel_we) begin
        o_write_addr <= BUS_W'(sel_addr);
        o_data       <= BUS_W'(sel_wdata);
      end
    end
  end

  // tag_v[0] lines up with o_read_en; tag_v[RD_LAT]
  // lines up with valid i_data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_v <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_v     <= {tag_v[RD_LAT-1:0], xfer & ~sel_we};
      tag_id[0] <= idx;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
    end else begin
      o_rsp_valid <= tag_v[RD_LAT] ?
        (NUM_CH'(1) << tag_id[RD_LAT]) : '0;
      if (tag_v[RD_LAT]) begin
        o_rsp_rdata <= i_data[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb at RD_LAT=1 and
// RD_LAT=3, both instances on shared stimulus.
module tb_mem_port_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   valid;
  logic [3:0]   we;
  logic [127:0] addr;
  logic [127:0] wdata;

  logic [3:0]  ready1, ready3;
  logic [3:0]  rspv1, rspv3;
  logic [31:0] rdata1, rdata3;
  logic        re1, re3, wen1, wen3;
  logic [63:0] raddr1, raddr3;
  logic [63:0] waddr1, waddr3;
  logic [63:0] wd1, wd3;
  logic [63:0] idata1 = '0;
  logic [63:0] m3 [3] = '{default: '0};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.RD_LAT(1)) dut1 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (valid),
    .i_req_we     (we),
    .i_req_addr   (addr),
    .i_req_wdata  (wdata),
    .o_req_ready  (ready1),
    .o_rsp_valid  (rspv1),
    .o_rsp_rdata  (rdata1),
    .o_read_en    (re1),
    .o_read_addr  (raddr1),
    .o_write_en   (wen1),
    .o_write_addr (waddr1),
    .o_data       (wd1),
    .i_data       (idata1)
  );

  mem_port_arb #(.RD_LAT(3)) dut3 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (valid),
    .i_req_we     (we),
    .i_req_addr   (addr),
    .i_req_wdata  (wdata),
    .o_req_ready  (ready3),
    .o_rsp_valid  (rspv3),
    .o_rsp_rdata  (rdata3),
    .o_read_en    (re3),
    .o_read_addr  (raddr3),
    .o_write_en   (wen3),
    .o_write_addr (waddr3),
    .o_data       (wd3),
    .i_data       (m3[2])
  );

  function automatic logic [63:0] mem_fn(
    input logic [63:0] a
  );
    if (a == 64'h10) return 64'h1122334455667788;
    return {32'h11112222, 32'h5A000000 | a[31:0]};
  endfunction

  // memory models: data valid RD_LAT cycles after
  // the read strobe cycle
  always @(posedge clk) begin
    idata1 <= mem_fn(raddr1);
    m3[0]  <= mem_fn(raddr3);
    m3[1]  <= m3[0];
    m3[2]  <= m3[1];
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic set_ch(input int c,
                        input logic v,
                        input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d);
    valid[c]         = v;
    we[c]            = w;
    addr[c*32 +: 32]  = a;
    wdata[c*32 +: 32] = d;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [3:0]  gexp [3] = '{4'b0001, 4'b1000, 4'b0010};
  int          chs  [3] = '{0, 3, 1};
  logic [3:0]  anyrsp;
  logic [3:0]  e1, e3;

  initial begin
    rst   = 1'b1;
    valid = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    for (int c = 0; c < 4; c++)
      set_ch(c, 1'b1, 1'b0, 32'h100 + 32'(4*c), '0);

    smp();
    chk("rst_ready", ready1, 0);
    chk("rst_re", re1, 0);
    chk("rst_we", wen1, 0);
    chk("rst_raddr", raddr1, 0);
    chk("rst_waddr", waddr1, 0);
    chk("rst_data", wd1, 0);
    chk("rst_rspv", rspv1, 0);
    chk("rst_rdata", rdata1, 0);

    next();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("fair_gnt", ready1, 4'b1 << (k % 4));
      if (k >= 1) begin
        chk("fair_re", re1, 1);
        chk("fair_raddr", raddr1,
            64'h100 + 64'(4*((k-1) % 4)));
      end
      if (k == 3) begin
        chk("fair_rspv0", rspv1, 4'b0001);
        chk("fair_rd0", rdata1, 32'h5A000100);
      end
      if (k == 4) begin
        chk("fair_rspv1", rspv1, 4'b0010);
        chk("fair_rd1", rdata1, 32'h5A000104);
      end
      next();
    end
    valid = '0;
    repeat (8) next();

    set_ch(2, 1'b1, 1'b0, 32'h10, '0);
    smp();
    chk("rd_gnt", ready1, 4'b0100);
    next();
    valid = '0;
    smp();
    chk("rd_re", re1, 1);
    chk("rd_raddr", raddr1, 64'h10);
    next();
    smp();
    chk("rd_early", rspv1, 0);
    next();
    smp();
    chk("rd_rspv", rspv1, 4'b0100);
    chk("rd_rdata", rdata1, 32'h55667788);
    next();
    next();
    smp();
    chk("rd3_rspv", rspv3, 4'b0100);
    chk("rd3_rdata", rdata3, 32'h55667788);
    next();

    set_ch(1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF);
    smp();
    chk("wr_gnt", ready1, 4'b0010);
    next();
    valid = '0;
    smp();
    chk("wr_en", wen1, 1);
    chk("wr_addr", waddr1, 64'h00000000FFFFFFFF);
    chk("wr_data", wd1, 64'h00000000DEADBEEF);
    chk("wr_no_re", re1, 0);
    anyrsp = '0;
    for (int k = 0; k < 6; k++) begin
      next();
      smp();
      anyrsp = anyrsp | rspv1 | rspv3;
      if (k == 0) begin
        chk("wr_once", wen1, 0);
        chk("wr_hold", waddr1, 64'hFFFFFFFF);
      end
    end
    chk("wr_no_rsp", anyrsp, 0);
    next();

    set_ch(3, 1'b1, 1'b1, 32'h40, 32'h1);
    smp();
    chk("ph_gnt3", ready1, 4'b1000);
    next();
    valid = '0;
    repeat (4) next();
    set_ch(0, 1'b1, 1'b1, 32'h44, 32'h2);
    set_ch(3, 1'b1, 1'b1, 32'h48, 32'h3);
    smp();
    chk("ph_gnt0", ready1, 4'b0001);
    next();
    valid[0] = 1'b0;
    smp();
    chk("ph_gnt3b", ready1, 4'b1000);
    next();
    valid = '0;
    repeat (2) next();

    for (int k = 0; k < 8; k++) begin
      valid = '0;
      if (k < 3)
        set_ch(chs[k], 1'b1, 1'b0,
               32'h20 + 32'(4*k), '0);
      smp();
      if (k < 3) chk("b2b_gnt", ready1, gexp[k]);
      e1 = (k >= 3 && k <= 5) ? gexp[k-3] : '0;
      e3 = (k >= 5 && k <= 7) ? gexp[k-5] : '0;
      chk("b2b_rspv1", rspv1, e1);
      chk("b2b_rspv3", rspv3, e3);
      if (e1 != 0)
        chk("b2b_rd1", rdata1,
            32'h5A000020 + 32'(4*(k-3)));
      if (e3 != 0)
        chk("b2b_rd3", rdata3,
            32'h5A000020 + 32'(4*(k-5)));
      next();
    end
    valid = '0;
    next();

    set_ch(2, 1'b1, 1'b0, 32'h30, '0);
    smp();
    chk("rm_gnt", ready1, 4'b0100);
    next();
    valid = '0;
    smp();
    chk("rm_re", re1, 1);
    chk("rm_raddr", raddr1, 64'h30);
    #1;
    rst   = 1'b1;
    valid = '1;
    we    = '1;
    #1;
    chk("rm_ready", ready1, 0);
    chk("rm_re0", re1, 0);
    chk("rm_raddr0", raddr1, 0);
    chk("rm_re3", re3, 0);
    next();
    rst = 1'b0;
    smp();
    chk("rm_ptr0", ready1, 4'b0001);
    next();
    valid = '0;
    anyrsp = '0;
    for (int k = 0; k < 8; k++) begin
      smp();
      anyrsp = anyrsp | rspv1 | rspv3;
      next();
    end
    chk("rm_drop", anyrsp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
